// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module : timer_pkg
// Brief  : Shared state/unit encodings, LED patterns and helpers for timer_ctrl
// Rev    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        ADJ   = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEC = 2'd0,
        MIN = 2'd1,
        HR  = 2'd2
    } sel_t;

    localparam logic [9:0] c_LED_RUN    = 10'h200;
    localparam logic [9:0] c_LED_PAUSE  = 10'h100;
    localparam logic [9:0] c_LED_DONE_A = 10'h155;
    localparam logic [9:0] c_LED_DONE_B = 10'h2AA;

    function automatic sel_t next_sel(input sel_t s);
        case (s)
            SEC:     return MIN;
            MIN:     return HR;
            default: return SEC;
        endcase
    endfunction

    function automatic logic [9:0] sel_led(input sel_t s);
        return 10'h001 << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : timer_ctrl_if
// Brief  : Front-panel controls in, datapath commands and status out
// Rev    : 1.0 - initial release
// ============================================================================
interface timer_ctrl_if;
    import timer_pkg::*;

    logic       stc;
    logic       inc;
    logic       run;
    logic       sw;
    logic       zero;
    sel_t       sel;
    logic       adj_up;
    logic       adj_dn;
    logic       cnt_dec;
    logic       blk;
    logic [9:0] led;
    logic [2:0] state;

    modport master (
        output stc, inc, run, sw, zero,
        input  sel, adj_up, adj_dn, cnt_dec, blk, led, state
    );

    modport slave (
        input  stc, inc, run, sw, zero,
        output sel, adj_up, adj_dn, cnt_dec, blk, led, state
    );

endinterface
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module : timer_prescaler
// Brief  : Divide-by-DIV counter with clear/hold and a one-cycle wrap tick
// Rev    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int DIV = 4
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  en,
    input  wire  clr,
    input  wire  hold,
    output logic tick
);

    localparam int             c_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_cnt;
    logic           w_step;

    assign w_step = en & ~hold & ~clr;
    assign tick   = w_step & (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : timer_ctrl
// Brief  : Countdown timer control FSM: button edges to one-cycle datapath cmds
// Rev    : 1.0 - initial release
// ============================================================================
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ALARM_SECS = 10
) (
    input wire          clk,
    input wire          rst_n,
    timer_ctrl_if.slave bus
);

    localparam int              c_AW         = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [c_AW-1:0] c_ALARM_LAST = c_AW'(ALARM_SECS - 1);

    state_t          r_state;
    sel_t            r_sel;
    logic            r_adj_up;
    logic            r_adj_dn;
    logic            r_cnt_dec;
    logic            r_blk;
    logic [9:0]      r_led;
    logic [c_AW-1:0] r_alarm;
    logic            r_stc_q;
    logic            r_inc_q;
    logic            r_run_q;

    logic w_stc_rise;
    logic w_inc_rise;
    logic w_run_rise;
    logic w_tick;
    logic w_blink_tick;
    logic w_blink_on;
    logic w_blink_clr;

    assign w_stc_rise = bus.stc & ~r_stc_q;
    assign w_inc_rise = bus.inc & ~r_inc_q;
    assign w_run_rise = bus.run & ~r_run_q;

    // Clear on the very edge PAUSE->ADJ happens so the blink restarts visible
    assign w_blink_on  = (r_state == ADJ) || (r_state == PAUSE);
    assign w_blink_clr = ~w_blink_on | ((r_state == PAUSE) & ~w_run_rise & w_stc_rise);

    timer_prescaler #(.DIV(TICK_DIV)) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (r_state != ADJ),
        .clr  (r_state == ADJ),
        .hold (r_state == PAUSE),
        .tick (w_tick)
    );

    timer_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (w_blink_on),
        .clr  (w_blink_clr),
        .hold (1'b0),
        .tick (w_blink_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ADJ;
            r_sel     <= SEC;
            r_adj_up  <= 1'b0;
            r_adj_dn  <= 1'b0;
            r_cnt_dec <= 1'b0;
            r_blk     <= 1'b0;
            r_led     <= 10'h001;
            r_alarm   <= '0;
            r_stc_q   <= 1'b0;
            r_inc_q   <= 1'b0;
            r_run_q   <= 1'b0;
        end else begin
            r_stc_q   <= bus.stc;
            r_inc_q   <= bus.inc;
            r_run_q   <= bus.run;
            r_adj_up  <= 1'b0;
            r_adj_dn  <= 1'b0;
            r_cnt_dec <= 1'b0;
            if (w_blink_tick) begin
                r_blk <= ~r_blk;
            end

            case (r_state)
                ADJ: begin
                    if (w_run_rise) begin
                        if (!bus.zero) begin
                            r_state <= RUN;
                            r_led   <= c_LED_RUN;
                            r_blk   <= 1'b0;
                        end
                    end else if (w_stc_rise) begin
                        r_sel <= next_sel(r_sel);
                        r_led <= sel_led(next_sel(r_sel));
                    end else if (w_inc_rise) begin
                        r_adj_up <= ~bus.sw;
                        r_adj_dn <= bus.sw;
                    end
                end

                RUN: begin
                    if (w_tick && !bus.zero) begin
                        r_cnt_dec <= 1'b1;
                    end
                    if (w_run_rise) begin
                        r_state <= PAUSE;
                        r_led   <= c_LED_PAUSE;
                    end else if (bus.zero) begin
                        r_state <= DONE;
                        r_led   <= c_LED_DONE_A;
                        r_alarm <= '0;
                    end
                end

                PAUSE: begin
                    if (w_run_rise) begin
                        r_blk <= 1'b0;
                        if (bus.zero) begin
                            r_state <= DONE;
                            r_led   <= c_LED_DONE_A;
                            r_alarm <= '0;
                        end else begin
                            r_state <= RUN;
                            r_led   <= c_LED_RUN;
                        end
                    end else if (w_stc_rise) begin
                        r_state <= ADJ;
                        r_sel   <= SEC;
                        r_led   <= sel_led(SEC);
                        r_blk   <= 1'b0;
                    end else if (w_inc_rise) begin
                        r_adj_up <= ~bus.sw;
                        r_adj_dn <= bus.sw;
                    end
                end

                DONE: begin
                    if (w_run_rise || w_stc_rise || w_inc_rise ||
                        (w_tick && (r_alarm == c_ALARM_LAST))) begin
                        r_state <= ADJ;
                        r_sel   <= SEC;
                        r_led   <= sel_led(SEC);
                        r_blk   <= 1'b0;
                    end else if (w_tick) begin
                        r_alarm <= r_alarm + 1'b1;
                        r_led   <= (r_led == c_LED_DONE_A) ? c_LED_DONE_B : c_LED_DONE_A;
                    end
                end

                default: r_state <= ADJ;
            endcase
        end
    end

    assign bus.sel     = r_sel;
    assign bus.adj_up  = r_adj_up;
    assign bus.adj_dn  = r_adj_dn;
    assign bus.cnt_dec = r_cnt_dec;
    assign bus.blk     = r_blk;
    assign bus.led     = r_led;
    assign bus.state   = {1'b0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_timer_ctrl
// Brief  : Scoreboard bench for timer_ctrl with TICK_DIV=4, BLINK_DIV=2, ALARM_SECS=3
// Rev    : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl;
    import timer_pkg::*;

    localparam int K_UP   = 0;
    localparam int K_DN   = 1;
    localparam int K_DEC  = 2;
    localparam int K_NONE = 7;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_dec  = 0;
    int   n_base = 0;
    int   t_load = 0;
    int   act_kind;
    exp_t q[$];
    exp_t e_front;

    timer_ctrl_if bus_if ();

    timer_ctrl #(
        .TICK_DIV  (4),
        .BLINK_DIV (2),
        .ALARM_SECS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: seconds remaining = t_load - decrements since load
    always @(posedge clk) if (bus_if.cnt_dec) n_dec <= n_dec + 1;
    assign bus_if.zero = ((n_dec - n_base) == t_load);

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int kind, input int at);
        q.push_back('{kind, at});
    endtask

    task automatic press(input logic s, input logic i, input logic r);
        bus_if.stc = s;
        bus_if.inc = i;
        bus_if.run = r;
        @(negedge clk);
        bus_if.stc = 1'b0;
        bus_if.inc = 1'b0;
        bus_if.run = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every command pulse must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].at < cyc) begin
                e_front = q.pop_front();
                check("pulse_missing_at_cycle", cyc, e_front.at);
            end
            if (bus_if.adj_up || bus_if.adj_dn || bus_if.cnt_dec) begin
                act_kind = bus_if.cnt_dec ? K_DEC : (bus_if.adj_dn ? K_DN : K_UP);
                check("single_cmd", $countones({bus_if.adj_up, bus_if.adj_dn, bus_if.cnt_dec}), 1);
                if (q.size() == 0) begin
                    check("unexpected_pulse_kind", act_kind, K_NONE);
                end else begin
                    e_front = q.pop_front();
                    check("pulse_kind", act_kind, e_front.kind);
                    check("pulse_cycle", cyc, e_front.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int p;
        int r;
        int e2;
        bus_if.stc = 1'b0;
        bus_if.inc = 1'b0;
        bus_if.run = 1'b0;
        bus_if.sw  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", bus_if.state, 0);
        check("rst_sel", bus_if.sel, 0);
        check("rst_led", bus_if.led, 10'h001);
        check("rst_blk", bus_if.blk, 0);
        check("rst_cmds", {bus_if.adj_up, bus_if.adj_dn, bus_if.cnt_dec}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unit select cycles SEC -> MIN -> HR -> SEC
        for (int k = 1; k <= 3; k++) begin
            press(1'b1, 1'b0, 1'b0);
            check("sel_step", bus_if.sel, k % 3);
            check("led_step", bus_if.led, 1 << (k % 3));
        end

        // Adjust MIN: ten up, one down
        press(1'b1, 1'b0, 1'b0);
        check("sel_min", bus_if.sel, 1);
        for (int k = 0; k < 10; k++) begin
            expect_pulse(K_UP, cyc + 1);
            press(1'b0, 1'b1, 1'b0);
        end
        bus_if.sw = 1'b1;
        expect_pulse(K_DN, cyc + 1);
        press(1'b0, 1'b1, 1'b0);
        bus_if.sw = 1'b0;
        check("sel_after_adj", bus_if.sel, 1);

        // Start refused while time is zero
        press(1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("start_refused_state", bus_if.state, 0);

        // Start with non-zero time: ticks at +4, +8, +12
        t_load = 100;
        n_base = n_dec;
        e = cyc + 1;
        expect_pulse(K_DEC, e + 4);
        expect_pulse(K_DEC, e + 8);
        expect_pulse(K_DEC, e + 12);
        press(1'b0, 1'b0, 1'b1);
        check("run_state", bus_if.state, 1);
        check("run_led", bus_if.led, 10'h200);
        check("run_blk", bus_if.blk, 0);

        // Pause two cycles after the third tick
        wait_cyc(e + 13);
        press(1'b0, 1'b0, 1'b1);
        p = e + 14;
        check("pause_state", bus_if.state, 2);
        check("pause_led", bus_if.led, 10'h100);
        check("pause_sel", bus_if.sel, 1);
        while (cyc < p + 19) begin
            check("pause_blk", bus_if.blk, ((cyc - p) >> 1) & 1);
            @(negedge clk);
        end

        // Resume with 3 s left: ticks at +2, +6, +10, then DONE
        t_load = 3;
        n_base = n_dec;
        r = cyc + 1;
        expect_pulse(K_DEC, r + 2);
        expect_pulse(K_DEC, r + 6);
        expect_pulse(K_DEC, r + 10);
        press(1'b0, 1'b0, 1'b1);
        check("resume_state", bus_if.state, 1);
        wait_cyc(r + 11);
        check("done_not_yet", bus_if.state, 1);
        wait_cyc(r + 12);
        check("done_state", bus_if.state, 3);
        check("done_led_a", bus_if.led, 10'h155);
        check("done_blk", bus_if.blk, 0);
        wait_cyc(r + 14);
        check("done_led_b", bus_if.led, 10'h2AA);
        wait_cyc(r + 18);
        check("done_led_a2", bus_if.led, 10'h155);
        wait_cyc(r + 21);
        check("done_hold", bus_if.state, 3);
        wait_cyc(r + 22);
        check("auto_return_state", bus_if.state, 0);
        check("auto_return_sel", bus_if.sel, 0);
        check("auto_return_led", bus_if.led, 10'h001);

        // Simultaneous run+stc: run wins, sel unchanged
        t_load = 100;
        n_base = n_dec;
        e2 = cyc + 1;
        expect_pulse(K_DEC, e2 + 4);
        press(1'b1, 1'b0, 1'b1);
        check("prio_state", bus_if.state, 1);
        check("prio_sel", bus_if.sel, 0);
        check("prio_led", bus_if.led, 10'h200);

        // Asynchronous reset mid-RUN
        wait_cyc(e2 + 5);
        #1 rst_n = 1'b0;
        #1;
        check("arst_state", bus_if.state, 0);
        check("arst_sel", bus_if.sel, 0);
        check("arst_led", bus_if.led, 10'h001);
        check("arst_blk", bus_if.blk, 0);
        check("arst_cmds", {bus_if.adj_up, bus_if.adj_dn, bus_if.cnt_dec}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_cmds", {bus_if.adj_up, bus_if.adj_dn, bus_if.cnt_dec}, 0);
            check("post_rst_state", bus_if.state, 0);
        end

        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
